// File: rtl/basgate_exerciser_pkg.sv
// Shared definitions for the basic-gate exerciser: state encoding, widths,
// gate output bit positions and the golden truth table.
package basgate_exerciser_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_W       = 2;
    localparam int unsigned Y_WIDTH     = 6;
    localparam int unsigned ERR_W       = 5;

    localparam int unsigned Y_AND  = 0;
    localparam int unsigned Y_NAND = 1;
    localparam int unsigned Y_OR   = 2;
    localparam int unsigned Y_NOR  = 3;
    localparam int unsigned Y_XOR  = 4;
    localparam int unsigned Y_NOTA = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Expected gate outputs for vector {A,B}; A is the MSB.
    function automatic logic [Y_WIDTH-1:0] golden_of(input logic [VEC_W-1:0] v);
        logic                a;
        logic                b;
        logic [Y_WIDTH-1:0]  y;
        a = v[1];
        b = v[0];
        y = '0;
        y[Y_AND]  = a & b;
        y[Y_NAND] = ~(a & b);
        y[Y_OR]   = a | b;
        y[Y_NOR]  = ~(a | b);
        y[Y_XOR]  = a ^ b;
        y[Y_NOTA] = ~a;
        return y;
    endfunction

endpackage

// File: rtl/basgate_golden.sv
// Combinational golden-value lookup for one {A,B} test vector.
module basgate_golden
    import basgate_exerciser_pkg::*;
(
    input  logic [VEC_W-1:0]   vec,
    output logic [Y_WIDTH-1:0] expected
);

    assign expected = golden_of(vec);

endmodule

// File: rtl/basgate_exerciser.sv
// In-system stimulus/response engine: sweeps A/B through all four vectors,
// waits a settle time, and accumulates mismatches against the golden table.
module basgate_exerciser
    import basgate_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a_out,
    output logic               b_out,
    input  logic [Y_WIDTH-1:0] y_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [Y_WIDTH-1:0] fail_mask,
    output logic [ERR_W-1:0]   err_count,
    output logic [VEC_W-1:0]   first_fail_vec
);

    // A settle time of zero would skip sampling entirely, so clamp to one.
    localparam int unsigned SETTLE_N = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W    = $clog2(SETTLE_N + 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [CNT_W-1:0]   cnt;
    logic [Y_WIDTH-1:0] golden;
    logic [Y_WIDTH-1:0] mismatch;

    function automatic logic [ERR_W-1:0] popcount(input logic [Y_WIDTH-1:0] v);
        logic [ERR_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(Y_WIDTH); i++) begin
            n = n + ERR_W'(v[i]);
        end
        return n;
    endfunction

    basgate_golden u_golden (
        .vec      (vec),
        .expected (golden)
    );

    assign mismatch = y_in ^ golden;

    // Sweep sequencer with registered outputs and result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            vec            <= '0;
            cnt            <= '0;
            a_out          <= 1'b0;
            b_out          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    if (start) begin
                        state          <= ST_DRIVE;
                        busy           <= 1'b1;
                        vec            <= '0;
                        fail_mask      <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    a_out <= vec[1];
                    b_out <= vec[0];
                    cnt   <= CNT_W'(SETTLE_N);
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    fail_mask <= fail_mask | mismatch;
                    err_count <= err_count + popcount(mismatch);
                    // An all-zero sticky mask means no earlier vector has failed.
                    if ((mismatch != '0) && (fail_mask == '0)) begin
                        first_fail_vec <= vec;
                    end
                    if (vec == VEC_LAST) begin
                        state <= ST_FINISH;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (fail_mask == '0);
                    a_out <= 1'b0;
                    b_out <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/basgate_exerciser.md
# basgate_exerciser

Self-checking stimulus and response engine for the two-input basic-gate block (Y1 AND, Y2 NAND, Y3 OR, Y4 NOR, Y5 XOR, Y6 NOT A).
- It drives the gate inputs A/B through all four combinations.
- It waits a programmable settle time, then samples the six gate outputs and compares them with golden values.
- It reports pass/fail, a per-output failure mask and a mismatch count.
- It sits between the lab-board start button / LEDs and the gate block, which it exercises in-system.

## Interface
- SETTLE_CYCLES, default 2: cycles between updating a_out/b_out and sampling y_in. A value of 0 is treated as 1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle request to run one full sweep; ignored while busy=1.
- a_out  out  1  drives gate input A.
- b_out  out  1  drives gate input B.
- y_in  in  6  gate outputs; bit 0 = Y1, bit 5 = Y6.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  1 when the last sweep had zero mismatches; held until the next start.
- fail_mask  out  6  sticky per-output mismatch flags for the current/last sweep.
- err_count  out  5  total mismatching output bits over the sweep, range 0..24.
- first_fail_vec  out  2  {A,B} of the first vector with any mismatch; valid only when pass=0 after done.

## Operation
- Golden values for vector {A,B}: Y1=A&B, Y2=~(A&B), Y3=A|B, Y4=~(A|B), Y5=A^B, Y6=~A.
- Vector order: 00, 01, 10, 11, with A as the MSB. vec is a 2-bit counter.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, FINISH.
  - IDLE: a_out=b_out=0, busy=0. On start=1, go to DRIVE and clear vec, fail_mask, err_count, first_fail_vec and pass.
  - DRIVE, 1 cycle: register a_out=vec[1], b_out=vec[0]. Load the settle counter with max(SETTLE_CYCLES,1). Go to SETTLE.
  - SETTLE: decrement the counter. When it reaches 1, go to CHECK.
  - CHECK, 1 cycle:
    - Compute mismatch = y_in ^ golden(vec).
    - fail_mask |= mismatch; err_count += popcount(mismatch).
    - If mismatch≠0 and no earlier failure was captured, first_fail_vec=vec.
    - If vec=3, go to FINISH; otherwise increment vec and go to DRIVE.
  - FINISH, 1 cycle: done=1, pass=(fail_mask==0), a_out=b_out=0. Go to IDLE.
- y_in is sampled unsynchronised. SETTLE_CYCLES must cover the gate block's pad-to-pad delay.
- start pulses while busy have no effect. A start in the FINISH cycle is ignored.
- err_count saturates at 24 by construction; no wrap handling is required.

## Timing
- Reset values: a_out=0, b_out=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, first_fail_vec=0; state is IDLE.
- With N = max(SETTLE_CYCLES,1), each vector takes N+2 cycles: DRIVE, N×SETTLE, CHECK.
- done is asserted 4·(N+2)+1 cycles after the edge that samples start. For the default N=2 this is cycle 17.
- busy rises on the edge after start and falls together with done.
- Reset asserted mid-sweep forces all outputs to their reset values immediately, since reset is asynchronous. No partial result is retained. After release the block waits in IDLE for a new start.

## Structure
- Shared package/include holds:
  - state encoding constants;
  - NUM_VECTORS=4 and Y_WIDTH=6;
  - bit-index constants Y_AND..Y_NOTA.
- Natural sub-module: basgate_golden. It is combinational: vec[1:0] in, expected[5:0] out. Reusing it keeps the golden table in one place for RTL and bench.
- Top contains the FSM, settle counter, vec counter and result registers. popcount is a local function.

## Test plan
- Correct gate model, N=2, one start -> done at cycle 17, pass=1, fail_mask=000000, err_count=0.
- Y5 stuck at 0 -> mismatches at vectors 01 and 10. Required: fail_mask=010000, err_count=2, first_fail_vec=01, pass=0.
- Y1 and Y2 swapped -> both bits wrong on every vector. Required: fail_mask=000011, err_count=8, first_fail_vec=00.
- Second start pulse at cycle 5 of a sweep -> ignored. Required: exactly one done pulse, at cycle 17; a/b sequence unchanged.
- rst_n low during SETTLE of vector 10, then released, then start with a correct model. Required: outputs zero while in reset; the new sweep reports pass=1 and err_count=0.
- SETTLE_CYCLES=0 -> behaves as N=1. Required: a/b changes every 3 cycles, done at cycle 13.
